// File: rtl/m3_bitstream_reader.sv
// m3_bitstream_reader: streams 16-bit SRAM words into a 64-bit MSB-aligned bit buffer
// and exposes the oldest 32 unconsumed bits as a left-aligned peek window.
module m3_bitstream_reader #(
    parameter logic [17:0] BASE_ADDR  = 18'd0,
    parameter logic [17:0] WORD_LIMIT = 18'd76800
) (
    input  logic        Clock_50,
    input  logic        Resetn,
    input  logic        start,
    input  logic [15:0] SRAM_read_data,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    output logic [31:0] peek_data,
    output logic        peek_valid,
    output logic [6:0]  bits_avail,
    input  logic        consume,
    input  logic [5:0]  consume_len,
    output logic        fetch_done,
    output logic        err
);
    localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2;

    logic [1:0]  state;
    logic [63:0] bit_buf;
    logic [17:0] ptr, words_issued, words_rcvd;
    // read pipeline: [0] address on bus, [1] SRAM access, [2] word held in rd_word
    logic [2:0]  pend;
    logic [15:0] rd_word;
    logic [1:0]  inflight;
    logic        issue, arrive, take_ok;
    logic [6:0]  kept;
    logic [63:0] shifted;

    assign inflight = 2'(pend[0]) + 2'(pend[1]) + 2'(pend[2]);
    assign issue    = state != IDLE && words_issued < WORD_LIMIT &&
                      ({1'b0, bits_avail} + {2'b0, inflight, 4'b0}) <= 8'd48;
    assign arrive   = pend[2];
    assign take_ok  = consume && consume_len <= 6'd32 && {1'b0, consume_len} <= bits_avail;
    assign kept     = take_ok ? bits_avail - {1'b0, consume_len} : bits_avail;
    assign shifted  = take_ok ? bit_buf << consume_len : bit_buf;

    assign SRAM_we_n  = 1'b1;
    assign peek_data  = bit_buf[63:32];
    assign peek_valid = bits_avail >= 7'd32 || (fetch_done && bits_avail != 7'd0);

    always_ff @(posedge Clock_50) begin
        if (!Resetn) begin
            state        <= IDLE;
            bit_buf      <= '0;
            bits_avail   <= '0;
            ptr          <= BASE_ADDR;
            words_issued <= '0;
            words_rcvd   <= '0;
            pend         <= '0;
            rd_word      <= '0;
            SRAM_address <= BASE_ADDR;
            fetch_done   <= 1'b0;
            err          <= 1'b0;
        end else if (start) begin
            // dropping the pipeline valids discards any words still in flight
            state        <= FILL;
            bit_buf      <= '0;
            bits_avail   <= '0;
            ptr          <= BASE_ADDR;
            words_issued <= '0;
            words_rcvd   <= '0;
            pend         <= '0;
            fetch_done   <= 1'b0;
            err          <= 1'b0;
        end else begin
            pend       <= {pend[1:0], issue};
            rd_word    <= SRAM_read_data;
            bit_buf    <= shifted | (arrive ? {rd_word, 48'b0} >> kept : 64'b0);
            bits_avail <= kept + (arrive ? 7'd16 : 7'd0);
            if (issue) begin
                SRAM_address <= ptr;
                ptr          <= ptr + 18'd1;
                words_issued <= words_issued + 18'd1;
            end
            if (arrive) begin
                words_rcvd <= words_rcvd + 18'd1;
                if (words_rcvd + 18'd1 == WORD_LIMIT)
                    fetch_done <= 1'b1;
            end
            if (consume && !take_ok)
                err <= 1'b1;
            if (state == FILL && (bits_avail >= 7'd32 || (fetch_done && bits_avail != 7'd0)))
                state <= RUN;
            else if (state == RUN && fetch_done && bits_avail == 7'd0)
                state <= IDLE;
        end
    end
endmodule
